// File: rtl/mc_serv_rf_if.sv
// -----------------------------------------------------------------------------
// mc_serv_rf_if
// Bundles the bit-serial register-file handshake between the SERV core and
// its register file.
//   rreq / wreq     : request a transfer (read and/or write)
//   ready           : one-cycle pulse, transfer starts on the following cycle
//   rreg0/1         : read addresses, latched at the request
//   rdata0/1        : serial read data, LSB first
//   wreg0/1         : write addresses, latched at the request
//   wen0/1, wdata0/1: per-bit write enable and serial write data
// Modports: master = core side, slave = register-file side.
// -----------------------------------------------------------------------------
interface mc_serv_rf_if #(
  parameter int AW = 6
);
  logic          rreq;
  logic          wreq;
  logic          ready;
  logic [AW-1:0] rreg0;
  logic [AW-1:0] rreg1;
  logic          rdata0;
  logic          rdata1;
  logic [AW-1:0] wreg0;
  logic [AW-1:0] wreg1;
  logic          wen0;
  logic          wen1;
  logic          wdata0;
  logic          wdata1;

  modport master (
    output rreq, wreq, rreg0, rreg1, wreg0, wreg1, wen0, wen1, wdata0, wdata1,
    input  ready, rdata0, rdata1
  );

  modport slave (
    input  rreq, wreq, rreg0, rreg1, wreg0, wreg1, wen0, wen1, wdata0, wdata1,
    output ready, rdata0, rdata1
  );
endinterface

// File: rtl/mc_serv_rf.sv
// -----------------------------------------------------------------------------
// mc_serv_rf
// Bit-serial register file for the SERV core. A request in IDLE latches the
// read/write addresses, waits LATENCY cycles (ready pulses in the last one),
// then streams WIDTH bits LSB first: read bits come combinationally from
// storage, write bits are stored at the edge that ends each bit cycle.
// Ports:
//   clk        : clock
//   i_rst      : synchronous active-high reset (FSM/outputs only, not storage)
//   rf         : serial RF bus (slave side of mc_serv_rf_if)
//   i_dbg_addr : debug read address
//   o_dbg_data : registered full-word debug read, one-cycle latency
// -----------------------------------------------------------------------------
module mc_serv_rf #(
  parameter int NREGS    = 64,
  parameter int WIDTH    = 32,
  parameter int LATENCY  = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             i_rst,
  mc_serv_rf_if.slave      rf,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] LAST_BIT  = KW'(WIDTH - 1);
  localparam logic [2:0]    LAT_FINAL = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_XFER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [KW-1:0] bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] rreg0_q, rreg0_d;
  logic [AW-1:0] rreg1_q, rreg1_d;
  logic [AW-1:0] wreg0_q, wreg0_d;
  logic [AW-1:0] wreg1_q, wreg1_d;
  logic [WIDTH-1:0] dbg_q;

  logic [WIDTH-1:0] mem_q [NREGS];

  // An address is backed by storage unless it is out of range or is the
  // hardwired-zero register; unbacked addresses read 0 and drop writes.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      bit_cnt_q <= '0;
      rreg0_q   <= '0;
      rreg1_q   <= '0;
      wreg0_q   <= '0;
      wreg1_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rreg0_q   <= rreg0_d;
      rreg1_q   <= rreg1_d;
      wreg0_q   <= wreg0_d;
      wreg1_q   <= wreg1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    bit_cnt_d = bit_cnt_q;
    rreg0_d   = rreg0_q;
    rreg1_d   = rreg1_q;
    wreg0_d   = wreg0_q;
    wreg1_d   = wreg1_q;
    case (state_q)
      ST_IDLE: begin
        if (rf.rreq || rf.wreq) begin
          rreg0_d   = rf.rreg0;
          rreg1_d   = rf.rreg1;
          wreg0_d   = rf.wreg0;
          wreg1_d   = rf.wreg1;
          lat_cnt_d = '0;
          // With LATENCY=1 the cycle right after the request is already the
          // ready cycle, so the wait phase is skipped entirely.
          state_d   = (LATENCY <= 1) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q + 3'd1;
        if (lat_cnt_d == LAT_FINAL) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d   = ST_XFER;
        bit_cnt_d = '0;
      end
      ST_XFER: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf.ready = (state_q == ST_READY);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Writes are gated only by the XFER state, so the bit of the cycle in which
  // reset is asserted is still stored; nothing after it is. Port 1 is written
  // last so it wins a same-bit collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_XFER) begin
      if (rf.wen0 && addr_ok(wreg0_q)) begin
        mem_q[wreg0_q][bit_cnt_q] <= rf.wdata0;
      end
      if (rf.wen1 && addr_ok(wreg1_q)) begin
        mem_q[wreg1_q][bit_cnt_q] <= rf.wdata1;
      end
    end
  end

  // Reads are combinational from storage, so a bit read in cycle k sees the
  // value from before the write that ends cycle k.
  assign rf.rdata0 = (state_q == ST_XFER) && addr_ok(rreg0_q) && mem_q[rreg0_q][bit_cnt_q];
  assign rf.rdata1 = (state_q == ST_XFER) && addr_ok(rreg1_q) && mem_q[rreg1_q][bit_cnt_q];

  // ---------------------------------------------------------------------------
  // Debug word port, independent of the FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_rst) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= addr_ok(i_dbg_addr) ? mem_q[i_dbg_addr] : '0;
    end
  end

  assign o_dbg_data = dbg_q;

endmodule

// File: tb/tb_mc_serv_rf.sv
// -----------------------------------------------------------------------------
// tb_mc_serv_rf
// Directed bench for mc_serv_rf. Two instances run the same stimulus side by
// side: dut_a with the hardwired-zero register, dut_b without it.
// -----------------------------------------------------------------------------
module tb_mc_serv_rf;
  localparam int NREGS   = 64;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;
  localparam int AW      = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_a, dbg_b;
  int               checks = 0;
  int               errors = 0;

  mc_serv_rf_if #(.AW(AW)) ifa ();
  mc_serv_rf_if #(.AW(AW)) ifb ();

  mc_serv_rf #(.NREGS(NREGS), .WIDTH(WIDTH), .LATENCY(LATENCY), .ZERO_REG(1)) dut_a (
    .clk(clk), .i_rst(rst), .rf(ifa.slave), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_a)
  );

  mc_serv_rf #(.NREGS(NREGS), .WIDTH(WIDTH), .LATENCY(LATENCY), .ZERO_REG(0)) dut_b (
    .clk(clk), .i_rst(rst), .rf(ifb.slave), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    ifa.rreq = 0; ifa.wreq = 0; ifa.rreg0 = '0; ifa.rreg1 = '0; ifa.wreg0 = '0; ifa.wreg1 = '0;
    ifa.wen0 = 0; ifa.wen1 = 0; ifa.wdata0 = 0; ifa.wdata1 = 0;
    ifb.rreq = 0; ifb.wreq = 0; ifb.rreg0 = '0; ifb.rreg1 = '0; ifb.wreg0 = '0; ifb.wreg1 = '0;
    ifb.wen0 = 0; ifb.wen1 = 0; ifb.wdata0 = 0; ifb.wdata1 = 0;
  endtask

  // One complete transfer on both instances. ready_ofs = edges between the
  // request edge and the cycle where ready is seen (12 means it never came).
  task automatic run_xfer(
    input  logic rq, input logic wq,
    input  logic [AW-1:0] rr0, input logic [AW-1:0] rr1,
    input  logic [AW-1:0] wr0, input logic [AW-1:0] wr1,
    input  logic [WIDTH-1:0] wm0, input logic [WIDTH-1:0] wm1,
    input  logic [WIDTH-1:0] wd0, input logic [WIDTH-1:0] wd1,
    input  int rst_at,
    output logic [WIDTH-1:0] ra0, output logic [WIDTH-1:0] ra1,
    output logic [WIDTH-1:0] rb0, output logic [WIDTH-1:0] rb1,
    output int ready_ofs, output int ready_extra);
    ra0 = '0; ra1 = '0; rb0 = '0; rb1 = '0; ready_extra = 0;
    ifa.rreq = rq; ifa.wreq = wq; ifa.rreg0 = rr0; ifa.rreg1 = rr1; ifa.wreg0 = wr0; ifa.wreg1 = wr1;
    ifb.rreq = rq; ifb.wreq = wq; ifb.rreg0 = rr0; ifb.rreg1 = rr1; ifb.wreg0 = wr0; ifb.wreg1 = wr1;
    tick;
    ifa.rreq = 0; ifa.wreq = 0; ifb.rreq = 0; ifb.wreq = 0;
    ready_ofs = 0;
    while (ifa.ready !== 1'b1 && ready_ofs < 12) begin
      tick;
      ready_ofs++;
    end
    if (ready_ofs >= 12) return;
    tick;
    for (int k = 0; k < WIDTH; k++) begin
      ifa.wen0 = wm0[k]; ifa.wen1 = wm1[k]; ifa.wdata0 = wd0[k]; ifa.wdata1 = wd1[k];
      ifb.wen0 = wm0[k]; ifb.wen1 = wm1[k]; ifb.wdata0 = wd0[k]; ifb.wdata1 = wd1[k];
      ra0[k] = ifa.rdata0; ra1[k] = ifa.rdata1; rb0[k] = ifb.rdata0; rb1[k] = ifb.rdata1;
      if (ifa.ready === 1'b1) ready_extra++;
      if (k == rst_at) rst = 1;
      tick;
      if (k == rst_at) begin
        rst = 0;
        break;
      end
    end
    ifa.wen0 = 0; ifa.wen1 = 0; ifa.wdata0 = 0; ifa.wdata1 = 0;
    ifb.wen0 = 0; ifb.wen1 = 0; ifb.wdata0 = 0; ifb.wdata1 = 0;
  endtask

  task automatic wr_reg(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] a0, a1, b0, b1;
    int ofs, ex;
    run_xfer(0, 1, '0, '0, addr, '0, '1, '0, data, '0, -1, a0, a1, b0, b1, ofs, ex);
  endtask

  task automatic rd_regs(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         output logic [WIDTH-1:0] a0, output logic [WIDTH-1:0] a1,
                         output logic [WIDTH-1:0] b0, output int ofs);
    logic [WIDTH-1:0] b1;
    int ex;
    run_xfer(1, 0, r0, r1, '0, '0, '0, '0, '0, '0, -1, a0, a1, b0, b1, ofs, ex);
  endtask

  task automatic test_reset;
    bus_idle();
    dbg_addr = '0;
    rst = 1;
    ifa.rreq = 1; ifb.rreq = 1;
    tick; tick;
    checks++; if (ifa.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ifa.ready); end
    checks++; if (ifa.rdata0 !== 1'b0 || ifa.rdata1 !== 1'b0) begin errors++; $display("FAIL reset_rdata: got %b%b expected 00", ifa.rdata1, ifa.rdata0); end
    checks++; if (dbg_a !== '0 || dbg_b !== '0) begin errors++; $display("FAIL reset_dbg: got %h/%h expected 0", dbg_a, dbg_b); end
    rst = 0;
    ifa.rreq = 0; ifb.rreq = 0;
    tick; tick; tick;
    checks++; if (ifa.ready !== 1'b0) begin errors++; $display("FAIL reset_no_req: got %b expected 0", ifa.ready); end
    $display("test_reset done");
  endtask

  task automatic test_latency;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    int ofs, ex;
    run_xfer(1, 0, 6'd1, 6'd2, '0, '0, '0, '0, '0, '0, -1, a0, a1, b0, b1, ofs, ex);
    checks++; if (ofs != LATENCY - 1) begin errors++; $display("FAIL latency_ofs: got %0d expected %0d", ofs, LATENCY - 1); end
    checks++; if (ex != 0) begin errors++; $display("FAIL latency_single_pulse: got %0d extra ready cycles expected 0", ex); end
    checks++; if (ifa.ready !== 1'b0 || ifa.rdata0 !== 1'b0) begin errors++; $display("FAIL latency_idle_after: got ready=%b rdata0=%b expected 0/0", ifa.ready, ifa.rdata0); end
    // Back-to-back request straight after the transfer ends.
    rd_regs(6'd3, 6'd4, a0, a1, b0, ofs);
    checks++; if (ofs != LATENCY - 1) begin errors++; $display("FAIL latency_back_to_back: got %0d expected %0d", ofs, LATENCY - 1); end
    $display("test_latency: ready offset %0d", ofs);
  endtask

  task automatic test_write_read;
    logic [WIDTH-1:0] a0, a1, b0;
    int ofs;
    wr_reg(6'd5, 32'hDEADBEEF);
    rd_regs(6'd5, 6'd5, a0, a1, b0, ofs);
    checks++; if (a0[7:0] !== 8'hEF) begin errors++; $display("FAIL wr_rd_first_bits: got %h expected ef", a0[7:0]); end
    checks++; if (a0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_port0: got %h expected deadbeef", a0); end
    checks++; if (a1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_port1: got %h expected deadbeef", a1); end
    checks++; if (b0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_nozero: got %h expected deadbeef", b0); end
    dbg_addr = 6'd5;
    tick;
    checks++; if (dbg_a !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_dbg: got %h expected deadbeef", dbg_a); end
    $display("test_write_read: reg5 = %h", a0);
  endtask

  task automatic test_zero_reg;
    logic [WIDTH-1:0] a0, a1, b0;
    int ofs;
    wr_reg(6'd0, 32'hFFFFFFFF);
    rd_regs(6'd0, 6'd0, a0, a1, b0, ofs);
    checks++; if (a0 !== '0 || a1 !== '0) begin errors++; $display("FAIL zero_reg_read: got %h/%h expected 0", a0, a1); end
    checks++; if (b0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL zero_reg_off_read: got %h expected ffffffff", b0); end
    dbg_addr = 6'd0;
    tick;
    checks++; if (dbg_a !== '0) begin errors++; $display("FAIL zero_reg_dbg: got %h expected 0", dbg_a); end
    checks++; if (dbg_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL zero_reg_off_dbg: got %h expected ffffffff", dbg_b); end
    $display("test_zero_reg: a=%h b=%h", a0, b0);
  endtask

  task automatic test_rw_same;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    int ofs, ex;
    wr_reg(6'd7, 32'h12345678);
    run_xfer(1, 1, 6'd7, 6'd7, 6'd7, '0, '1, '0, 32'hA5A5A5A5, '0, -1, a0, a1, b0, b1, ofs, ex);
    checks++; if (a0 !== 32'h12345678) begin errors++; $display("FAIL rw_same_old: got %h expected 12345678", a0); end
    checks++; if (a1 !== 32'h12345678) begin errors++; $display("FAIL rw_same_old_p1: got %h expected 12345678", a1); end
    rd_regs(6'd7, 6'd0, a0, a1, b0, ofs);
    checks++; if (a0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_same_new: got %h expected a5a5a5a5", a0); end
    $display("test_rw_same: reg7 = %h", a0);
  endtask

  task automatic test_collision;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    int ofs, ex;
    run_xfer(0, 1, '0, '0, 6'd3, 6'd3, '1, '1, 32'h00000000, 32'hFFFFFFFF, -1, a0, a1, b0, b1, ofs, ex);
    rd_regs(6'd3, 6'd3, a0, a1, b0, ofs);
    checks++; if (a0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL collision_port1_wins: got %h expected ffffffff", a0); end
    run_xfer(0, 1, '0, '0, 6'd8, 6'd9, '1, '1, 32'h0F0F0F0F, 32'h3C3C3C3C, -1, a0, a1, b0, b1, ofs, ex);
    rd_regs(6'd8, 6'd9, a0, a1, b0, ofs);
    checks++; if (a0 !== 32'h0F0F0F0F) begin errors++; $display("FAIL dual_write_reg8: got %h expected 0f0f0f0f", a0); end
    checks++; if (a1 !== 32'h3C3C3C3C) begin errors++; $display("FAIL dual_write_reg9: got %h expected 3c3c3c3c", a1); end
    $display("test_collision: reg8=%h reg9=%h", a0, a1);
  endtask

  task automatic test_partial_wen;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    int ofs, ex;
    wr_reg(6'd10, 32'h00000000);
    run_xfer(0, 1, '0, '0, 6'd10, '0, 32'h0000FFFF, '0, 32'hFFFFFFFF, '0, -1, a0, a1, b0, b1, ofs, ex);
    rd_regs(6'd10, 6'd10, a0, a1, b0, ofs);
    checks++; if (a0 !== 32'h0000FFFF) begin errors++; $display("FAIL partial_wen: got %h expected 0000ffff", a0); end
    $display("test_partial_wen: reg10 = %h", a0);
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    int ofs, ex;
    bit seen;
    wr_reg(6'd12, 32'h00000000);
    run_xfer(0, 1, '0, '0, 6'd12, '0, '1, '0, 32'hFFFFFFFF, '0, 10, a0, a1, b0, b1, ofs, ex);
    checks++; if (ifa.ready !== 1'b0 || ifa.rdata0 !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got ready=%b rdata0=%b expected 0/0", ifa.ready, ifa.rdata0); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifa.ready === 1'b1) seen = 1;
      tick;
    end
    checks++; if (seen) begin errors++; $display("FAIL reset_mid_no_ready: got ready pulse expected none"); end
    rd_regs(6'd12, 6'd12, a0, a1, b0, ofs);
    checks++; if (ofs != LATENCY - 1) begin errors++; $display("FAIL reset_mid_new_req: got %0d expected %0d", ofs, LATENCY - 1); end
    checks++; if (a0 !== 32'h000007FF) begin errors++; $display("FAIL reset_mid_partial: got %h expected 000007ff", a0); end
    $display("test_reset_mid: reg12 = %h", a0);
  endtask

  initial begin
    rst = 1;
    dbg_addr = '0;
    bus_idle();
    test_reset();
    test_latency();
    test_write_read();
    test_zero_reg();
    test_rw_same();
    test_collision();
    test_partial_wen();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
